// File: rtl/rpn_calc_pkg.sv
// Shared FSM state encoding and ALU opcodes for the RPN stack calculator.
package rpn_calc_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ENTER = 3'd1,
        OPSEL = 3'd2,
        EXEC  = 3'd3,
        SHOW  = 3'd4,
        ERROR = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_MIN = 3'd5;
    localparam logic [2:0] OP_MAX = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

endpackage

// File: rtl/rpn_stack_calculator_if.sv
// Button/encoder inputs and display/status outputs of the RPN calculator.
interface rpn_stack_calculator_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             push;
    logic             operate;
    logic             restart;
    logic [WIDTH-1:0] rotary_value;
    logic [WIDTH-1:0] display_value;
    logic             display_load;
    logic             flag;
    logic             error;
    logic [CNT_W-1:0] stack_count;

    modport master (
        output push, operate, restart, rotary_value,
        input  display_value, display_load, flag, error, stack_count
    );

    modport slave (
        input  push, operate, restart, rotary_value,
        output display_value, display_load, flag, error, stack_count
    );
endinterface

// File: rtl/rpn_alu.sv
// Combinational ALU for the RPN calculator: R = B op A plus a status flag.
// Optional macro SATURATE_EN clamps ADD overflow to all-ones and SUB underflow to zero.
module rpn_alu import rpn_calc_pkg::*; #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] r,
    output logic             flag
);
`ifdef SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH:0] s);
        return s[WIDTH-1:0] | {WIDTH{s[WIDTH] & SAT}};
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH:0] d);
        return s_clear(d[WIDTH-1:0], d[WIDTH] & SAT);
    endfunction

    function automatic logic [WIDTH-1:0] s_clear(input logic [WIDTH-1:0] v, input logic clr);
        return v & ~{WIDTH{clr}};
    endfunction

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, b} + {1'b0, a};
    assign diff = {1'b0, b} - {1'b0, a};

    always_comb begin
        r    = '0;
        flag = 1'b0;
        case (op)
            OP_ADD: begin r = sat_add(sum);  flag = sum[WIDTH];  end
            OP_SUB: begin r = sat_sub(diff); flag = diff[WIDTH]; end
            OP_AND: begin r = b & a; flag = ~|(b & a); end
            OP_OR:  begin r = b | a; flag = ~|(b | a); end
            OP_XOR: begin r = b ^ a; flag = ~|(b ^ a); end
            OP_MIN: begin r = (b < a) ? b : a; flag = ~|((b < a) ? b : a); end
            OP_MAX: begin r = (b > a) ? b : a; flag = ~|((b > a) ? b : a); end
            default: begin r = b; flag = (a == b); end
        endcase
    end
endmodule

// File: rtl/rpn_stack_calculator.sv
// RPN stack calculator: button edge detect, DEPTH-entry operand stack, control FSM.
// Build option SATURATE_EN (handled in rpn_alu) selects saturating ADD/SUB.
module rpn_stack_calculator import rpn_calc_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                 clk_div,
    input  logic                 rst,
    rpn_stack_calculator_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    state_t           state, state_n;
    logic             push_d1, op_d1;
    logic             push_p, op_p;
    logic             do_push, do_exec;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] disp, disp_n;
    logic             load, load_n;
    logic             flag_r, error_r;
    logic [IDX_W-1:0] idx_push, idx_a, idx_b;
    logic [WIDTH-1:0] alu_r;
    logic             alu_flag;

    // A simultaneous operate edge is discarded when push rises in the same cycle.
    assign push_p = bus.push & ~push_d1;
    assign op_p   = bus.operate & ~op_d1 & ~push_p;

    assign idx_push = IDX_W'(cnt);
    assign idx_a    = IDX_W'(cnt - CNT_W'(1));
    assign idx_b    = IDX_W'(cnt - CNT_W'(2));

    rpn_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (stack[idx_a]),
        .b    (stack[idx_b]),
        .op   (opcode),
        .r    (alu_r),
        .flag (alu_flag)
    );

    always_comb begin
        state_n = state;
        do_push = 1'b0;
        do_exec = 1'b0;
        case (state)
            IDLE:  if (push_p) state_n = ENTER;
            ENTER: begin
                if (push_p) begin
                    if (cnt < CNT_W'(DEPTH)) do_push = 1'b1;
                    else                     state_n = ERROR;
                end else if (op_p) begin
                    state_n = OPSEL;
                end
            end
            OPSEL: begin
                if (push_p)    state_n = EXEC;
                else if (op_p) state_n = ENTER;
            end
            EXEC: begin
                if (cnt < CNT_W'(2)) begin
                    state_n = ERROR;
                end else begin
                    do_exec = 1'b1;
                    state_n = SHOW;
                end
            end
            SHOW:  if (push_p || op_p) state_n = ENTER;
            ERROR: if (push_p) state_n = ENTER;
            default: state_n = IDLE;
        endcase
        if (bus.restart) begin
            state_n = IDLE;
            do_push = 1'b0;
            do_exec = 1'b0;
        end

        // Display registers follow the state being entered; EXEC holds the previous view.
        disp_n = disp;
        load_n = load;
        case (state_n)
            ENTER: begin disp_n = bus.rotary_value; load_n = 1'b1; end
            OPSEL: begin disp_n = {{(WIDTH-3){1'b0}}, bus.rotary_value[2:0]}; load_n = 1'b1; end
            SHOW:  begin if (do_exec) disp_n = alu_r; load_n = 1'b1; end
            ERROR: begin disp_n = '1; load_n = 1'b1; end
            EXEC:  ;
            default: begin disp_n = '0; load_n = 1'b0; end
        endcase
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            state   <= IDLE;
            push_d1 <= 1'b0;
            op_d1   <= 1'b0;
            cnt     <= '0;
            opcode  <= '0;
            disp    <= '0;
            load    <= 1'b0;
            flag_r  <= 1'b0;
            error_r <= 1'b0;
            for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
        end else begin
            state   <= state_n;
            push_d1 <= bus.push;
            op_d1   <= bus.operate;
            disp    <= disp_n;
            load    <= load_n;
            error_r <= (state_n == ERROR);
            if (bus.restart) begin
                cnt    <= '0;
                flag_r <= 1'b0;
                for (int i = 0; i < DEPTH; i++) stack[i] <= '0;
            end else begin
                if (state == OPSEL && push_p) opcode <= bus.rotary_value[2:0];
                if (do_push) begin
                    stack[idx_push] <= bus.rotary_value;
                    cnt             <= cnt + CNT_W'(1);
                end
                if (do_exec) begin
                    stack[idx_b] <= alu_r;
                    cnt          <= cnt - CNT_W'(1);
                    flag_r       <= alu_flag;
                end
            end
        end
    end

    assign bus.display_value = disp;
    assign bus.display_load  = load;
    assign bus.flag          = flag_r;
    assign bus.error         = error_r;
    assign bus.stack_count   = cnt;
endmodule

// File: doc/rpn_stack_calculator.md
Name: rpn_stack_calculator

Overview:
- Parametrised successor to the single-shot two-operand calculator: operands are pushed onto a DEPTH-entry stack and binary ops are applied RPN-style (pop two, push one), so operations chain without re-entry.
- Sits between the rotary-encoder/debouncer front end (already-debounced, clk_div-synchronous levels) and the seven-segment decoder/LED flag.
- Owns button edge detection, stack, FSM and ALU result/flag generation.

Parameters:
- WIDTH, 8, operand/result width in bits (>=4).
- DEPTH, 4, stack entries (>=2).
- CNT_W, $clog2(DEPTH+1), width of stack_count.

Ports:
- clk_div  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- push  in  1  debounced select/push button level.
- operate  in  1  debounced operate button level.
- restart  in  1  debounced restart level; clears stack.
- rotary_value  in  WIDTH  current rotary-encoder count.
- display_value  out  WIDTH  value for seven-segment decoder.
- display_load  out  1  display enable.
- flag  out  1  ALU flag LED.
- error  out  1  overflow/underflow indicator.
- stack_count  out  CNT_W  number of valid stack entries.

Behaviour:
- Edge detect: push_p = push & ~push_d1, likewise op_p; push_d1/op_d1 registered every cycle, cleared by rst. Push_p and op_p in the same cycle: push_p wins, op_p dropped.
- Reset: state=IDLE, stack_count=0, all stack entries 0, display_value=0, display_load=0, flag=0, error=0.
- restart level has top priority in every state: next cycle is IDLE, stack cleared, flag=0, error=0.
- IDLE: display_load=0. push_p -> ENTER.
- ENTER: display_value=rotary_value, display_load=1.
  - push_p with stack_count<DEPTH: write rotary_value at top, count+1, stay in ENTER.
  - push_p with stack_count==DEPTH: -> ERROR; stack unchanged.
  - op_p -> OPSEL.
- OPSEL: display_value = zero-extended rotary_value[2:0], display_load=1.
  - push_p: latch opcode, -> EXEC.
  - op_p: -> ENTER (cancel).
- EXEC (exactly one cycle, no button sampling):
  - stack_count<2: -> ERROR.
  - Else: A=top, B=second; pop both, push result R (count-1); flag registered; -> SHOW.
- Opcodes:
  - 0 ADD R=B+A, flag=carry out.
  - 1 SUB R=B-A, flag=borrow.
  - 2 AND, 3 OR, 4 XOR, 5 MIN (unsigned), 6 MAX (unsigned); flag=(R==0).
  - 7 EQ: R=B, flag=(A==B).
  - All arithmetic modulo 2^WIDTH unless SATURATE_EN.
- SHOW: display_value=R, display_load=1, flag held. push_p or op_p -> ENTER; flag holds until next EXEC or restart.
- ERROR: error=1, display_value=all ones, display_load=1. push_p -> ENTER, error=0; stack retained. Only restart clears the stack.
- Latency: push_p to stack_count update = 1 cycle; opcode-latch push_p to result visible on display_value = 2 cycles (EXEC, then SHOW register).
- display_value and display_load are registered outputs.
- Unused state encodings -> IDLE.

Optional Feature:
- SATURATE_EN defined: ADD overflow yields all-ones and SUB underflow yields 0; flag still reports carry/borrow.
- Undefined: wrap-around modulo 2^WIDTH.

Decomposition:
- Shared package rpn_calc_pkg holds state localparams (IDLE, ENTER, OPSEL, EXEC, SHOW, ERROR) and opcode localparams (OP_ADD..OP_EQ).
- One sub-module, rpn_alu: combinational, WIDTH-parametrised, inputs a, b, op[2:0], outputs r, flag; SATURATE_EN handled inside it.
- Stack and FSM stay in the top module.

Test Plan:
- WIDTH=8: rst, push_p (IDLE->ENTER), push 0x05, push 0x03, op_p, rotary 1, push_p -> display_value=0x02, flag=0, stack_count=1 two cycles after.
- Push 0xF0, push 0x20, ADD -> default build: display 0x10, flag=1; SATURATE_EN: 0xFF, flag=1.
- DEPTH=4: push 4 values, fifth push_p -> error=1, display 0xFF, stack_count=4; push_p -> ENTER, error=0.
- One entry on stack, execute EQ -> ERROR, stack_count stays 1; two equal entries 0x3C, EQ -> flag=1, display 0x3C, count=1.
- Three entries, assert restart during OPSEL -> next cycle IDLE, stack_count=0, flag=0, display_load=0.
- push and operate rising the same cycle in ENTER -> push taken (count+1), state remains ENTER.
